// File: rtl/mem_responder.sv
`default_nettype none

// ============================================================================
//  Module   : mem_responder
//  Purpose  : Single-port word memory with byte-lane CPU writes, a full-word
//             loader (boot) write port, a fixed two-cycle pipelined read path,
//             sticky out-of-range / collision error flags and access counters.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             a_mem, sd_mem       - CPU word address and store data
//             mem_write, mem_en   - CPU byte-lane write enables, access enable
//             ld_mem, ld_valid    - registered load data, one-cycle valid pulse
//             boot_we/addr/data   - loader full-word write
//             err_clr             - clears oor_err / col_err
//             oor_err, col_err    - sticky out-of-range / dropped-write flags
//             rd_count, wr_count  - wrapping counts of reads / accepted writes
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_MEMDATA_ADDR
`define LEN_MEMDATA_ADDR 8
`endif

module mem_responder #(
    parameter int ADDR_W = `LEN_MEMDATA_ADDR,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    a_mem,
    input  logic [`LEN_WORD-1:0] sd_mem,
    input  logic [3:0]           mem_write,
    input  logic                 mem_en,
    output logic [`LEN_WORD-1:0] ld_mem,
    output logic                 ld_valid,
    input  logic                 boot_we,
    input  logic [ADDR_W-1:0]    boot_addr,
    input  logic [`LEN_WORD-1:0] boot_data,
    input  logic                 err_clr,
    output logic                 oor_err,
    output logic                 col_err,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);

    localparam int              c_W     = `LEN_WORD;
    localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    // Storage: deliberately not reset.
    logic [c_W-1:0] mem_q [DEPTH];

    // Pipeline and status registers.
    logic [c_W-1:0] s1_data_q,  s1_data_d;
    logic           s1_valid_q, s1_valid_d;
    logic [c_W-1:0] ld_mem_q,   ld_mem_d;
    logic           ld_valid_q, ld_valid_d;
    logic           oor_q,      oor_d;
    logic           col_q,      col_d;
    logic [15:0]    rd_cnt_q,   rd_cnt_d;
    logic [15:0]    wr_cnt_q,   wr_cnt_d;

    // Access decode.
    logic               w_cpu_rd;
    logic               w_cpu_wr;
    logic               w_cpu_inr;
    logic               w_boot_inr;
    logic               w_cpu_wr_ok;
    logic               w_boot_ok;
    logic [c_IDX_W-1:0] w_cpu_idx;
    logic [c_IDX_W-1:0] w_boot_idx;
    logic [c_W-1:0]     w_rd_word;

    assign w_cpu_rd    = mem_en && (mem_write == 4'b0000);
    assign w_cpu_wr    = mem_en && (mem_write != 4'b0000);
    assign w_cpu_inr   = ({1'b0, a_mem} < c_DEPTH);
    assign w_boot_inr  = ({1'b0, boot_addr} < c_DEPTH);
    assign w_cpu_idx   = a_mem[c_IDX_W-1:0];
    assign w_boot_idx  = boot_addr[c_IDX_W-1:0];
    assign w_boot_ok   = boot_we && w_boot_inr;
    // The loader owns the array in a shared cycle; the CPU write is dropped.
    assign w_cpu_wr_ok = w_cpu_wr && w_cpu_inr && !boot_we;
    // Out-of-range reads return zero rather than an aliased word.
    assign w_rd_word   = w_cpu_inr ? mem_q[w_cpu_idx] : '0;

    // Array write port. The read above samples the array before this edge
    // updates it, giving read-first behaviour against a same-cycle write.
    always_ff @(posedge clk) begin
        if (w_boot_ok) begin
            mem_q[w_boot_idx] <= boot_data;
        end else if (w_cpu_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_write[i]) begin
                    mem_q[w_cpu_idx][8*i +: 8] <= sd_mem[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        s1_data_d  = s1_data_q;
        s1_valid_d = w_cpu_rd;
        ld_mem_d   = ld_mem_q;
        ld_valid_d = s1_valid_q;
        oor_d      = oor_q;
        col_d      = col_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        if (w_cpu_rd) begin
            s1_data_d = w_rd_word;
            rd_cnt_d  = rd_cnt_q + 16'd1;
        end
        // ld_mem only changes when a read completes.
        if (s1_valid_q) begin
            ld_mem_d = s1_data_q;
        end
        if (w_cpu_wr_ok) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end

        // Setting wins over clearing in the same cycle.
        if (err_clr) begin
            oor_d = 1'b0;
            col_d = 1'b0;
        end
        if ((mem_en && !w_cpu_inr) || (boot_we && !w_boot_inr)) begin
            oor_d = 1'b1;
        end
        if (boot_we && w_cpu_wr) begin
            col_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            ld_mem_q   <= '0;
            ld_valid_q <= 1'b0;
            oor_q      <= 1'b0;
            col_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            ld_mem_q   <= ld_mem_d;
            ld_valid_q <= ld_valid_d;
            oor_q      <= oor_d;
            col_q      <= col_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign ld_mem   = ld_mem_q;
    assign ld_valid = ld_valid_q;
    assign oor_err  = oor_q;
    assign col_err  = col_q;
    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none

// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder (ADDR_W=8, DEPTH=16).
//             Read results are checked by a scoreboard keyed on due cycle.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  a_mem = '0;
    logic [31:0] sd_mem = '0;
    logic [3:0]  mem_write = '0;
    logic        mem_en = 1'b0;
    logic [31:0] ld_mem;
    logic        ld_valid;
    logic        boot_we = 1'b0;
    logic [7:0]  boot_addr = '0;
    logic [31:0] boot_data = '0;
    logic        err_clr = 1'b0;
    logic        oor_err;
    logic        col_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    mem_responder #(.ADDR_W(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_mem     (a_mem),
        .sd_mem    (sd_mem),
        .mem_write (mem_write),
        .mem_en    (mem_en),
        .ld_mem    (ld_mem),
        .ld_valid  (ld_valid),
        .boot_we   (boot_we),
        .boot_addr (boot_addr),
        .boot_data (boot_data),
        .err_clr   (err_clr),
        .oor_err   (oor_err),
        .col_err   (col_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] base;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[6];

    // Read-completion monitor: every ld_valid pulse must match the oldest
    // outstanding read, on exactly its due cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ld_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: ld_valid=1 ld_mem=%h at cycle %0d, required no pulse", ld_mem, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.due != cyc || ld_mem !== mon_e.data) begin
                        errors++;
                        $display("FAIL rd_data: ld_mem=%h at cycle %0d, required %h at cycle %0d",
                                 ld_mem, cyc, mon_e.data, mon_e.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL rd_missing: ld_valid=0 at cycle %0d, required %h", cyc, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_en = 1'b0; mem_write = '0; boot_we = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic boot(input logic [7:0] a, input logic [31:0] d);
        boot_we = 1'b1; boot_addr = a; boot_data = d;
        tick();
        boot_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        mem_en = 1'b1; mem_write = 4'b0000; a_mem = a;
        sb.push_back('{exp, cyc + 2});
        exp_rd++;
        tick();
        mem_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        mem_en = 1'b1; mem_write = m; a_mem = a; sd_mem = d;
        tick();
        mem_en = 1'b0; mem_write = '0;
    endtask

    initial begin
        tbl[0] = '{8'd10, 32'h01020304, 4'b0001, 32'hAABBCCDD, 32'h010203DD};
        tbl[1] = '{8'd11, 32'h01020304, 4'b1000, 32'hAABBCCDD, 32'hAA020304};
        tbl[2] = '{8'd12, 32'hFFFFFFFF, 4'b0110, 32'h00000000, 32'hFF0000FF};
        tbl[3] = '{8'd13, 32'h12345678, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[4] = '{8'd14, 32'h12345678, 4'b1010, 32'h9ABCDEF0, 32'h9A34DE78};
        tbl[5] = '{8'd15, 32'h00000000, 4'b0011, 32'h0000BEEF, 32'h0000BEEF};

        // Reset state
        tick(); tick();
        chk("rst_ld_mem",   ld_mem, 32'h0);
        chk("rst_ld_valid", 32'(ld_valid), 32'h0);
        chk("rst_oor",      32'(oor_err), 32'h0);
        chk("rst_col",      32'(col_err), 32'h0);
        chk("rst_rd_count", 32'(rd_count), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        rst = 1'b0;
        idle(1);

        // Boot write then CPU read, data held afterwards
        boot(8'd5, 32'hDEADBEEF);
        rd(8'd5, 32'hDEADBEEF);
        idle(4);
        chk("hold_ld_mem",   ld_mem, 32'hDEADBEEF);
        chk("hold_ld_valid", 32'(ld_valid), 32'h0);
        chk("rd_count_1",    32'(rd_count), 32'(exp_rd));

        // Byte-lane write, read on the very next cycle
        boot(8'd7, 32'h11223344);
        wr(8'd7, 4'b0101, 32'hAABBCCDD); exp_wr++;
        rd(8'd7, 32'h11BB33DD);
        idle(3);
        chk("wr_count_1", 32'(wr_count), 32'(exp_wr));

        // Back-to-back reads
        for (int i = 0; i < 4; i++) boot(8'(i), 32'(i));
        for (int i = 0; i < 4; i++) rd(8'(i), 32'(i));
        idle(4);

        // Table of lane-write vectors
        for (int i = 0; i < 6; i++) begin
            boot(tbl[i].addr, tbl[i].base);
            wr(tbl[i].addr, tbl[i].mask, tbl[i].wdata); exp_wr++;
            rd(tbl[i].addr, tbl[i].exp);
        end
        idle(3);
        chk("rd_count_tbl", 32'(rd_count), 32'(exp_rd));
        chk("wr_count_tbl", 32'(wr_count), 32'(exp_wr));

        // Loader / CPU write collision
        boot_we = 1'b1; boot_addr = 8'd9; boot_data = 32'h1;
        mem_en = 1'b1; mem_write = 4'hF; a_mem = 8'd9; sd_mem = 32'h2;
        tick();
        idle(0);
        chk("col_set",      32'(col_err), 32'h1);
        chk("col_wr_count", 32'(wr_count), 32'(exp_wr));
        rd(8'd9, 32'h1);
        // Collision again with err_clr: the set wins
        boot_we = 1'b1; boot_addr = 8'd9; boot_data = 32'h1;
        mem_en = 1'b1; mem_write = 4'hF; a_mem = 8'd9; sd_mem = 32'h3;
        err_clr = 1'b1;
        tick();
        idle(0);
        chk("col_set_wins", 32'(col_err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("col_clr", 32'(col_err), 32'h0);

        // Read-first against a same-cycle loader write
        boot_we = 1'b1; boot_addr = 8'd9; boot_data = 32'h55;
        mem_en = 1'b1; mem_write = 4'b0000; a_mem = 8'd9;
        sb.push_back('{32'h1, cyc + 2});
        exp_rd++;
        tick();
        idle(0);
        rd(8'd9, 32'h55);
        idle(3);

        // Out-of-range accesses
        chk("oor_clear0", 32'(oor_err), 32'h0);
        rd(8'd20, 32'h0);
        chk("oor_rd_set", 32'(oor_err), 32'h1);
        idle(3);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("oor_clr", 32'(oor_err), 32'h0);
        boot(8'd4, 32'h44);
        wr(8'd20, 4'hF, 32'h00000BAD);
        chk("oor_wr_set", 32'(oor_err), 32'h1);
        rd(8'd4, 32'h44);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        boot(8'd16, 32'h77);
        chk("oor_boot_set", 32'(oor_err), 32'h1);
        rd(8'd0, 32'h0);
        idle(3);

        // Reset with a read in flight
        rd(8'd5, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        sb.delete();
        exp_rd = 0;
        chk("arst_ld_mem",   ld_mem, 32'h0);
        chk("arst_ld_valid", 32'(ld_valid), 32'h0);
        chk("arst_rd_count", 32'(rd_count), 32'h0);
        chk("arst_oor",      32'(oor_err), 32'h0);
        tick(); tick();
        rst = 1'b0;
        idle(4);
        chk("post_rst_ld_mem", ld_mem, 32'h0);
        rd(8'd5, 32'hDEADBEEF);
        idle(3);
        chk("post_rst_rd_count", 32'(rd_count), 32'(exp_rd));

        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d reads outstanding, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default `LEN_MEMDATA_ADDR, the word-address width.
REQ-002 SHALL have parameter DEPTH, default 2**ADDR_W, the number of implemented words (at most 2**ADDR_W).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port a_mem, input, ADDR_W, the word address from the initiator.
REQ-006 SHALL have port sd_mem, input, `LEN_WORD, the store data.
REQ-007 SHALL have port mem_write, input, 4, the byte-lane write enables; bit i covers sd_mem[8i+7:8i].
REQ-008 SHALL have port mem_en, input, 1, the access enable.
REQ-009 SHALL have port ld_mem, output, `LEN_WORD, the registered load data.
REQ-010 SHALL have port ld_valid, output, 1, a one-cycle pulse when ld_mem carries fresh read data.
REQ-011 SHALL have port boot_we, input, 1, the loader full-word write strobe.
REQ-012 SHALL have port boot_addr, input, ADDR_W, the loader word address.
REQ-013 SHALL have port boot_data, input, `LEN_WORD, the loader write data.
REQ-014 SHALL have port err_clr, input, 1, which clears the sticky error flags.
REQ-015 SHALL have port oor_err, output, 1, sticky: an access targeted an address at or above DEPTH.
REQ-016 SHALL have port col_err, output, 1, sticky: a CPU write was dropped because of a loader write.
REQ-017 SHALL have port rd_count, output, 16, the number of accepted reads, wrapping.
REQ-018 SHALL have port wr_count, output, 16, the number of accepted CPU writes, wrapping.

Function
REQ-019 SHALL treat cycle T with mem_en=1 and mem_write=4'b0000 as a read and cycle T with mem_en=1 and mem_write!=0 as a write; mem_en=0 SHALL be idle.
REQ-020 SHALL use a fixed read latency of 2: array word -> stage-1 register at the end of T; stage-1 -> ld_mem at the end of T+1; ld_mem is valid throughout T+2.
REQ-021 SHALL pulse ld_valid high for exactly cycle T+2 of each read.
REQ-022 SHALL hold ld_mem stable between read completions; writes and idle cycles do not alter it.
REQ-023 SHALL accept one read per cycle, fully pipelined; back-to-back reads complete on consecutive cycles, in order.
REQ-024 SHALL update only the enabled byte lanes on a CPU write, at the end of T; the other lanes keep their old values.
REQ-025 SHALL return the newly written data for a read issued at T+1 of a word written at T.
REQ-026 SHALL perform a boot_we write of boot_data to boot_addr at the end of its cycle, regardless of mem_en.
REQ-027 SHALL, when boot_we and a CPU write occur in the same cycle, perform only the loader write, drop the CPU write, set col_err, and not increment wr_count.
REQ-028 SHALL, when boot_we and a CPU read occur in the same cycle, let the read proceed read-first: the same address returns pre-write data.
REQ-029 SHALL, for a CPU access with a_mem >= DEPTH, ignore the write or return 0 for the read (latency and ld_valid unchanged), and set oor_err.
REQ-030 SHALL ignore a loader write with boot_addr >= DEPTH and set oor_err.
REQ-031 SHALL let a set condition win over err_clr in the same cycle; otherwise err_clr clears both flags at the next edge.
REQ-032 SHALL increment rd_count at the end of each read-launch cycle (T).
REQ-033 SHALL increment wr_count at the end of each accepted CPU write cycle.
REQ-034 SHALL wrap both counters from 16'hFFFF to 0.

Reset
REQ-035 SHALL, on rst=1, immediately force ld_mem=0, ld_valid=0, the stage-1 register=0, oor_err=0, col_err=0, rd_count=0 and wr_count=0.
REQ-036 SHALL NOT clear array contents on reset.
REQ-037 SHALL discard a read in flight when reset asserts; no ld_valid for it after release.
REQ-038 SHALL treat the first edge with rst=0 as a normal cycle.

Verification
REQ-039 SHALL be verified by: boot-write 0xDEADBEEF@5; CPU read@5 at T -> ld_mem=0xDEADBEEF and ld_valid=1 at T+2 only, rd_count=1.
REQ-040 SHALL be verified by: word 0x11223344@7; write mem_write=4'b0101, sd_mem=0xAABBCCDD; read@7 next cycle -> 0x11BB33DD at +2.
REQ-041 SHALL be verified by: reads @0,1,2,3 on consecutive cycles holding 0..3 -> ld_mem 0,1,2,3 on four consecutive cycles, ld_valid high for four cycles.
REQ-042 SHALL be verified by: boot_we@9=0x1 with CPU write@9=0x2 in the same cycle -> word 0x1, col_err=1, wr_count unchanged; err_clr -> col_err=0 next cycle.
REQ-043 SHALL be verified by: DEPTH=16, read@20 -> ld_mem=0 at +2, ld_valid=1, oor_err=1.
REQ-044 SHALL be verified by: read issued, rst pulsed at T+1 -> ld_mem=0 and ld_valid never asserts; a later read of an unchanged word returns its pre-reset value.
